// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered result/flag stage with two-entry skid buffer
// Captures add/subtract results with derived status flags behind a valid/ready
// handshake, buffering up to two entries so upstream can stream while downstream stalls.
// Also keeps a wrapping accepted-operation count and a sticky overflow flag.
module alu_result_stage #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             select,
  input  logic [N-1:0]     result,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] op_count,
  output logic             sticky_ovf,
  input  logic             clear
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   main_result_q;
  logic [3:0]     main_flags_q;
  logic [N-1:0]   skid_result_q;
  logic [3:0]     skid_flags_q;
  logic           in_ready_q;
  logic           out_valid_q;

  logic           accept;
  logic           xfer;
  logic           ovf;
  logic [3:0]     in_flags;
  logic           load_main_in;
  logic           load_main_skid;
  logic           load_skid;

  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid_q && out_ready;

  // Status flags of the incoming result; overflow rule depends on add vs subtract.
  always_comb begin
    ovf = 1'b0;
    if (select == 1'b0) begin
      ovf = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
    end else begin
      ovf = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
    end
    in_flags = {ovf, result[N-1], (result == '0), cout};
  end

  // Storage state register; the handshake outputs are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Next storage state and which register loads from where.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (xfer) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Main (output-facing) and skid data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_result_q <= '0;
      main_flags_q  <= '0;
      skid_result_q <= '0;
      skid_flags_q  <= '0;
    end else begin
      if (load_main_in) begin
        main_result_q <= result;
        main_flags_q  <= in_flags;
      end else if (load_main_skid) begin
        main_result_q <= skid_result_q;
        main_flags_q  <= skid_flags_q;
      end
      if (load_skid) begin
        skid_result_q <= result;
        skid_flags_q  <= in_flags;
      end
    end
  end

  // Accepted-operation counter and sticky overflow; clear beats a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count   <= '0;
      sticky_ovf <= 1'b0;
    end else if (clear) begin
      op_count   <= '0;
      sticky_ovf <= 1'b0;
    end else if (accept) begin
      op_count <= op_count + CNT_W'(1);
      if (in_flags[3]) begin
        sticky_ovf <= 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = main_result_q;
  assign out_flags  = main_flags_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
module tb_alu_result_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       select;
  logic [3:0] result;
  logic       cout;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [3:0] out_flags;
  logic [7:0] op_count;
  logic       sticky_ovf;
  logic       clear;

  int checks = 0;
  int errors = 0;

  alu_result_stage #(.N(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .select     (select),
    .result     (result),
    .cout       (cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .op_count   (op_count),
    .sticky_ovf (sticky_ovf),
    .clear      (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [3:0] ia, input logic [3:0] ib,
                       input logic [3:0] r, input logic c);
    in_valid = v;
    select   = s;
    a        = ia;
    b        = ib;
    result   = r;
    cout     = c;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_op_count", op_count, 0);
    check("rst_sticky", sticky_ovf, 0);
    step();
    rst_n = 1'b1;

    // Add overflow: 7 + 1 = 8
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0);
    step();
    in_valid = 1'b0;
    check("add_out_valid", out_valid, 1);
    check("add_out_result", out_result, 4'b1000);
    check("add_flags", out_flags, 4'b1100);
    check("add_sticky", sticky_ovf, 1);
    check("add_op_count", op_count, 1);
    step();
    check("add_drained", out_valid, 0);

    // Subtract to zero with carry: 3 - 3
    drive(1'b1, 1'b1, 4'b0011, 4'b0011, 4'b0000, 1'b1);
    step();
    in_valid = 1'b0;
    check("sub_out_result", out_result, 0);
    check("sub_flags", out_flags, 4'b0011);
    check("sub_sticky", sticky_ovf, 1);
    check("sub_op_count", op_count, 2);
    step();

    // Clear without accept
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_op_count", op_count, 0);
    check("clr_sticky", sticky_ovf, 0);

    // Stall: stream 1, 2, 3 with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 1'b0);
    step();
    check("stall1_in_ready", in_ready, 1);
    check("stall1_out_result", out_result, 1);
    check("stall1_flags", out_flags, 4'b0000);
    result = 4'h2;
    step();
    check("stall2_in_ready", in_ready, 0);
    check("stall2_out_result", out_result, 1);
    result = 4'h3;
    step();
    check("stall3_in_ready", in_ready, 0);
    check("stall3_stable", out_result, 1);
    check("stall3_op_count", op_count, 2);
    out_ready = 1'b1;
    step();
    check("rel1_out_valid", out_valid, 1);
    check("rel1_out_result", out_result, 2);
    check("rel1_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("rel2_out_valid", out_valid, 1);
    check("rel2_out_result", out_result, 3);
    check("rel2_op_count", op_count, 3);
    step();
    check("rel3_out_valid", out_valid, 0);

    // Continuous streaming at full rate
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 4'h0, 4'h0, 4'(i + 4), 1'b0);
      step();
      check("stream_in_ready", in_ready, 1);
      check("stream_out_valid", out_valid, 1);
      check("stream_out_result", out_result, 32'(i + 4));
    end
    in_valid = 1'b0;
    step();
    check("stream_op_count", op_count, 9);

    // Counter wrap after 256 accepts
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 4'h0, 4'h0, 4'(i), 1'b0);
      step();
      if (i == 254) check("wrap_255", op_count, 255);
    end
    in_valid = 1'b0;
    check("wrap_0", op_count, 0);
    step();

    // Clear together with an overflowing accept
    drive(1'b1, 1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0);
    clear = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clracc_op_count", op_count, 0);
    check("clracc_sticky", sticky_ovf, 0);
    check("clracc_out_valid", out_valid, 1);
    check("clracc_out_result", out_result, 4'b1000);
    step();

    // Asynchronous reset while two entries are buffered
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h9, 1'b0);
    step();
    result = 4'hA;
    step();
    in_valid = 1'b0;
    check("two_in_ready", in_ready, 0);
    check("two_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_in_ready", in_ready, 1);
    check("async_op_count", op_count, 0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    check("post_rst_out_valid", out_valid, 0);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 4'hB, 1'b0);
    step();
    in_valid = 1'b0;
    check("post_rst_result", out_result, 4'hB);
    check("post_rst_valid", out_valid, 1);
    step();
    check("post_rst_drained", out_valid, 0);
    check("post_rst_op_count", op_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the add/subtract arithmetic unit.
- Captures the unit's result and carry, together with the operands and select that produced them, behind a valid/ready handshake.
- Derives status flags (carry, zero, negative, signed overflow) and buffers up to two results in a skid buffer, so upstream can stream one operation per cycle while downstream stalls.
- Keeps a wrapping count of accepted operations and a sticky overflow flag for the status path.

Parameters:
- N, 4, operand/result width; must match the arithmetic unit (N >= 2).
- CNT_W, 8, width of the accepted-operation counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents a result this cycle
- in_ready  out  1  stage can accept; registered output
- a  in  N  operand A that produced the result
- b  in  N  operand B that produced the result
- select  in  1  0 = add, 1 = subtract (same encoding as the arithmetic unit)
- result  in  N  arithmetic unit out
- cout  in  1  arithmetic unit cout
- out_valid  out  1  out_result/out_flags hold a valid entry
- out_ready  in  1  downstream accepts this cycle
- out_result  out  N  buffered result
- out_flags  out  4  {overflow, negative, zero, carry}
- op_count  out  CNT_W  number of accepted inputs, modulo 2^CNT_W
- sticky_ovf  out  1  set by any accepted overflow result
- clear  in  1  synchronous clear of op_count and sticky_ovf

Behaviour:
- Reset (rst_n low, asynchronous), all outputs and state:
  - in_ready=1, out_valid=0, out_result=0, out_flags=0, op_count=0, sticky_ovf=0.
  - Main and skid registers empty.
- Flags are computed combinationally from the inputs and captured at acceptance:
  - carry = cout.
  - zero = (result == 0).
  - negative = result[N-1].
  - overflow when select=0: a[N-1]==b[N-1] and result[N-1]!=a[N-1].
  - overflow when select=1: a[N-1]!=b[N-1] and result[N-1]!=a[N-1].
- Accept condition: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Storage states:
  - EMPTY: main empty, skid empty.
  - ONE: main full.
  - TWO: main and skid full.
- Transitions on each clock edge:
  - EMPTY + accept -> ONE; entry goes into main; out_valid=1 the next cycle (latency 1).
  - ONE + accept + transfer -> ONE; main is reloaded with the new entry.
  - ONE + accept, no transfer -> TWO; entry goes into skid; in_ready=0 from the next cycle.
  - ONE + transfer, no accept -> EMPTY; out_valid=0 the next cycle.
  - TWO + transfer -> ONE; skid moves to main; in_ready=1 the next cycle.
  - TWO: no accept is possible because in_ready=0.
- Ordering is strictly FIFO. No entry may be dropped or duplicated.
- out_result/out_flags stay stable while out_valid && !out_ready.
- in_ready depends only on registered state, with no combinational path from out_ready.
- Data held in an empty register is don't-care, but the outputs present the last main contents.
- op_count increments by 1 on each accept and wraps from 2^CNT_W-1 to 0.
- sticky_ovf is set on an accept whose overflow=1.
- clear has priority over a same-cycle accept:
  - op_count=0 and sticky_ovf=0 after the edge.
  - The accepted data is still buffered.
- Reset asserted mid-operation discards all buffered entries immediately; no transfer may complete after reset.

Test Plan:
- N=4, out_ready=1, select=0, a=0111, b=0001, result=1000, cout=0, one pulse -> out_valid one cycle later; out_result=1000; flags {ovf=1, neg=1, zero=0, carry=0}; sticky_ovf=1; op_count=1.
- select=1, a=0011, b=0011, result=0000, cout=1 -> flags {0,0,1,1}; sticky_ovf unchanged.
- out_ready=0, stream 3 inputs (results 1, 2, 3) back-to-back:
  - 1 and 2 are accepted; in_ready=0 from the cycle after the second accept; 3 is held.
  - Raising out_ready delivers 1, 2, 3 in order with no gaps after the first stall release; op_count=3.
- Continuous in_valid with out_ready=1 -> one transfer per cycle and in_ready stays 1 throughout.
- CNT_W=8, 256 accepts -> op_count returns to 0. clear together with an accept -> op_count=0 and the data is still output.
- rst_n low while in state TWO -> out_valid=0 and in_ready=1 immediately (asynchronously); the next accept yields only the new data.
